// File: rtl/divider_iterative.sv
// Iterative radix-2 restoring divider for the RV32M divide group
// (DIV, DIVU, REM, REMU). One quotient bit is retired per cycle; divide-by-zero
// and signed overflow skip the loop and complete one edge after acceptance.
// The handshake (startD / done / div_use) matches the iterative multiplier.
module divider_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startD,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_divide,
    output logic            done,
    output logic            div_use
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Two's-complement negation, wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a signed operand; INT_MIN maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? negate(v) : v;
    endfunction

    state_t            state_q, state_d;
    logic              op_rem_q, op_rem_d;      // 1: REM/REMU, 0: DIV/DIVU
    logic              sign_q_q, sign_q_d;      // negate quotient at the end
    logic              sign_r_q, sign_r_d;      // negate remainder at the end
    logic [XLEN-1:0]   dvd_q, dvd_d;            // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]   rem_q, rem_d;            // partial remainder (always < divisor)
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    // Working values for one restoring step; the shifted remainder needs one
    // extra bit so the compare against the divisor is exact.
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_diff;
    logic              op_signed;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; all cleared so a reset aborts cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_rem_q  <= 1'b0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            dvd_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            op_rem_q  <= op_rem_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: operand capture / fast path, restoring step, result.
    always_comb begin
        state_d   = state_q;
        op_rem_d  = op_rem_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        op_signed = ~div_opcode[0];
        rem_shift = {rem_q, dvd_q[XLEN-1]};
        rem_diff  = rem_shift[XLEN-1:0] - divisor_q;

        case (state_q)
            S_IDLE: begin
                if (startD) begin
                    op_rem_d = div_opcode[1];
                    cnt_d    = '0;
                    rem_d    = '0;
                    state_d  = S_ITER;
                    if (op_signed) begin
                        sign_q_d  = operand1[XLEN-1] ^ operand2[XLEN-1];
                        sign_r_d  = operand1[XLEN-1];
                        dvd_d     = magnitude(operand1);
                        divisor_d = magnitude(operand2);
                    end else begin
                        sign_q_d  = 1'b0;
                        sign_r_d  = 1'b0;
                        dvd_d     = operand1;
                        divisor_d = operand2;
                    end
                    // Fast paths: load the final quotient/remainder directly
                    // and let FIN select between them, without sign fix-up.
                    if (operand2 == '0) begin
                        sign_q_d = 1'b0;
                        sign_r_d = 1'b0;
                        dvd_d    = '1;
                        rem_d    = operand1;
                        state_d  = S_FIN;
                    end else if (op_signed && operand1 == INT_MIN && operand2 == '1) begin
                        sign_q_d = 1'b0;
                        sign_r_d = 1'b0;
                        dvd_d    = INT_MIN;
                        rem_d    = '0;
                        state_d  = S_FIN;
                    end
                end
            end

            S_ITER: begin
                if (rem_shift >= {1'b0, divisor_q}) begin
                    rem_d = rem_diff;
                    dvd_d = {dvd_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                if (op_rem_q) begin
                    result_d = sign_r_q ? negate(rem_q) : rem_q;
                end else begin
                    result_d = sign_q_q ? negate(dvd_q) : dvd_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result_divide = result_q;
    assign done          = done_q;
    // Stall the pipeline from the request cycle until the block is idle again.
    assign div_use       = (state_q != S_IDLE) | startD;

endmodule

// File: tb/tb_divider_iterative.sv
// Directed testbench for divider_iterative: hand-computed results, latency,
// div_use stall window, ignored restarts, back-to-back starts and mid-op reset.
module tb_divider_iterative;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk;
    logic        rst;
    logic        startD;
    logic [1:0]  div_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result_divide;
    logic        done;
    logic        div_use;

    int n_chk  = 0;
    int n_pass = 0;

    divider_iterative #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .startD        (startD),
        .div_opcode    (div_opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .result_divide (result_divide),
        .done          (done),
        .div_use       (div_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request before an edge and hold it through the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        startD     = 1'b1;
        @(posedge clk);
        #1;
        startD     = 1'b0;
    endtask

    // Count edges after the accept edge until done, bounded; also track div_use.
    task automatic wait_done(output int lat, output logic use_ok);
        lat    = 0;
        use_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!div_use) use_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic use_ok;
        @(negedge clk);
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        startD     = 1'b1;
        #1;
        chk({tag, "_use_req"}, 32'(div_use), 32'd1);
        @(posedge clk);
        #1;
        startD = 1'b0;
        wait_done(lat, use_ok);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result_divide, exp);
        chk({tag, "_use_busy"}, 32'(use_ok), 32'd1);
        chk({tag, "_use_done"}, 32'(div_use), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   lat;
        logic use_ok;
        int   bad;

        rst        = 1'b0;
        startD     = 1'b0;
        div_opcode = 2'b00;
        operand1   = '0;
        operand2   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", result_divide, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_use", 32'(div_use), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Normal iterative path
        run_op("divu_100_7",  OP_DIVU, 32'd100,       32'd7, 32'd14,        33);
        run_op("rem_m7_2",    OP_REM,  32'hFFFFFFF9,  32'd2, 32'hFFFFFFFF,  33);
        run_op("div_m7_2",    OP_DIV,  32'hFFFFFFF9,  32'd2, 32'hFFFFFFFD,  33);
        run_op("remu_m7_2",   OP_REMU, 32'hFFFFFFF9,  32'd2, 32'd1,         33);
        run_op("div_m100_7",  OP_DIV,  32'hFFFFFF9C,  32'd7, 32'hFFFFFFF2,  33);
        run_op("rem_m100_7",  OP_REM,  32'hFFFFFF9C,  32'd7, 32'hFFFFFFFE,  33);
        run_op("divu_max_1",  OP_DIVU, 32'hFFFFFFFF,  32'd1, 32'hFFFFFFFF,  33);
        run_op("div_min_m1u", OP_DIVU, 32'h80000000,  32'hFFFFFFFF, 32'd0,  33);

        // Fast paths
        run_op("divu_x_0",    OP_DIVU, 32'h12345678,  32'd0, 32'hFFFFFFFF,  1);
        run_op("remu_x_0",    OP_REMU, 32'h12345678,  32'd0, 32'h12345678,  1);
        run_op("div_5_0",     OP_DIV,  32'd5,         32'd0, 32'hFFFFFFFF,  1);
        run_op("rem_m7_0",    OP_REM,  32'hFFFFFFF9,  32'd0, 32'hFFFFFFF9,  1);
        run_op("div_ovf",     OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",     OP_REM,  32'h80000000,  32'hFFFFFFFF, 32'h0,  1);

        // startD during ITER is ignored; a start in the done cycle is accepted
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (10) @(posedge clk);
        @(negedge clk);
        div_opcode = OP_REMU;
        operand1   = 32'd77;
        operand2   = 32'd5;
        startD     = 1'b1;
        @(negedge clk);
        startD     = 1'b0;
        operand1   = 32'hDEADBEEF;
        #1;
        wait_done(lat, use_ok);
        chk("ignore_lat", 32'(lat + 11), 32'd33);
        chk("ignore_res", result_divide, 32'd100);
        // Still inside the done cycle: request the next operation now.
        chk("b2b_done", 32'(done), 32'd1);
        issue(OP_DIVU, 32'd50, 32'd5);
        wait_done(lat, use_ok);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_res", result_divide, 32'd10);
        chk("b2b_use", 32'(use_ok), 32'd1);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        issue(OP_DIVU, 32'h0000FFFF, 32'd3);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_res", result_divide, 32'h0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_use", 32'(div_use), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || div_use) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
